// File: rtl/tmds_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmds_pkg
// Purpose  : Shared TMDS widths, control symbols, disparity type, popcount.
// Revision : 1.0
// ============================================================================
package tmds_pkg;

    localparam int TMDS_W = 10;

    localparam logic [TMDS_W-1:0] CTRL_00 = 10'b1101010100;
    localparam logic [TMDS_W-1:0] CTRL_01 = 10'b0010101011;
    localparam logic [TMDS_W-1:0] CTRL_10 = 10'b0101010100;
    localparam logic [TMDS_W-1:0] CTRL_11 = 10'b1010101011;

    typedef logic signed [4:0] disp_t;

    function automatic logic [3:0] popcount8(input logic [7:0] d);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, d[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : tmds_encoder_if
// Purpose  : Pixel/timing bus into the encoder and the three TMDS lanes out.
// Revision : 1.0
// ============================================================================
interface tmds_encoder_if;
    import tmds_pkg::*;

    logic              data_enable;
    logic              horz_sync;
    logic              vert_sync;
    logic [7:0]        red;
    logic [7:0]        green;
    logic [7:0]        blue;
    logic [TMDS_W-1:0] tmds_ch0;
    logic [TMDS_W-1:0] tmds_ch1;
    logic [TMDS_W-1:0] tmds_ch2;

    modport master (
        output data_enable, horz_sync, vert_sync, red, green, blue,
        input  tmds_ch0, tmds_ch1, tmds_ch2
    );

    modport slave (
        input  data_enable, horz_sync, vert_sync, red, green, blue,
        output tmds_ch0, tmds_ch1, tmds_ch2
    );

endinterface
`default_nettype wire

// File: rtl/tmds_channel_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_channel_encoder
// Purpose  : One TMDS lane: transition-minimising stage, DC-balancing stage.
// Revision : 1.0
// ============================================================================
module tmds_channel_encoder
    import tmds_pkg::*;
(
    input  wire                clk,
    input  wire                rst_n,
    input  wire                i_de,
    input  wire  [1:0]         i_ctrl,
    input  wire  [7:0]         i_data,
    output logic [TMDS_W-1:0]  o_tmds
);

    logic [3:0]        w_n1_d;
    logic              w_use_xnor;
    logic [8:0]        w_qm;

    logic [8:0]        r_qm;
    logic              r_de;
    logic [1:0]        r_ctrl;

    logic [3:0]        w_n1;
    logic [3:0]        w_n0;
    disp_t             w_diff;
    logic              w_q8;
    logic [TMDS_W-1:0] w_sym;
    disp_t             w_cnt_nxt;

    logic [TMDS_W-1:0] r_out;
    disp_t             r_cnt;

    always_comb begin
        w_n1_d     = popcount8(i_data);
        w_use_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !i_data[0]);
        w_qm       = 9'd0;
        w_qm[0]    = i_data[0];
        for (int i = 1; i < 8; i++) begin
            w_qm[i] = w_use_xnor ? (w_qm[i-1] ~^ i_data[i]) : (w_qm[i-1] ^ i_data[i]);
        end
        w_qm[8]    = !w_use_xnor;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_qm   <= 9'd0;
            r_de   <= 1'b0;
            r_ctrl <= 2'b00;
        end else begin
            r_qm   <= w_qm;
            r_de   <= i_de;
            r_ctrl <= i_ctrl;
        end
    end

    // Differences stay at 5-bit signed so cnt never sees a wider operand.
    always_comb begin
        w_n1      = popcount8(r_qm[7:0]);
        w_n0      = 4'd8 - w_n1;
        w_diff    = disp_t'({1'b0, w_n1}) - disp_t'({1'b0, w_n0});
        w_q8      = r_qm[8];
        w_sym     = CTRL_00;
        w_cnt_nxt = 5'sd0;
        if (!r_de) begin
            case (r_ctrl)
                2'b00:   w_sym = CTRL_00;
                2'b01:   w_sym = CTRL_01;
                2'b10:   w_sym = CTRL_10;
                default: w_sym = CTRL_11;
            endcase
        end else if ((r_cnt == 5'sd0) || (w_n1 == w_n0)) begin
            w_sym     = {~w_q8, w_q8, w_q8 ? r_qm[7:0] : ~r_qm[7:0]};
            w_cnt_nxt = w_q8 ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if (((r_cnt > 5'sd0) && (w_n1 > w_n0)) ||
                     ((r_cnt < 5'sd0) && (w_n0 > w_n1))) begin
            w_sym     = {1'b1, w_q8, ~r_qm[7:0]};
            w_cnt_nxt = r_cnt + {3'b000, w_q8, 1'b0} - w_diff;
        end else begin
            w_sym     = {1'b0, w_q8, r_qm[7:0]};
            w_cnt_nxt = r_cnt - {3'b000, ~w_q8, 1'b0} + w_diff;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= CTRL_00;
            r_cnt <= 5'sd0;
        end else begin
            r_out <= w_sym;
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_tmds = r_out;

endmodule
`default_nettype wire

// File: rtl/tmds_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tmds_encoder
// Purpose  : Three-lane DVI TMDS encoder (ch0 blue+sync, ch1 green, ch2 red).
// Revision : 1.0
// ============================================================================
module tmds_encoder
    import tmds_pkg::*;
#(
    parameter int OUT_REG = 0
) (
    input  wire            clock_25,
    input  wire            reset_n,
    tmds_encoder_if.slave  bus
);

    logic [TMDS_W-1:0] w_sym0;
    logic [TMDS_W-1:0] w_sym1;
    logic [TMDS_W-1:0] w_sym2;

    // Only the blue lane carries sync; green and red send C1C0 = 00 in blanking.
    tmds_channel_encoder u_ch0 (
        .clk    (clock_25),
        .rst_n  (reset_n),
        .i_de   (bus.data_enable),
        .i_ctrl ({bus.vert_sync, bus.horz_sync}),
        .i_data (bus.blue),
        .o_tmds (w_sym0)
    );

    tmds_channel_encoder u_ch1 (
        .clk    (clock_25),
        .rst_n  (reset_n),
        .i_de   (bus.data_enable),
        .i_ctrl (2'b00),
        .i_data (bus.green),
        .o_tmds (w_sym1)
    );

    tmds_channel_encoder u_ch2 (
        .clk    (clock_25),
        .rst_n  (reset_n),
        .i_de   (bus.data_enable),
        .i_ctrl (2'b00),
        .i_data (bus.red),
        .o_tmds (w_sym2)
    );

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [TMDS_W-1:0] r_ch0;
            logic [TMDS_W-1:0] r_ch1;
            logic [TMDS_W-1:0] r_ch2;

            always_ff @(posedge clock_25) begin
                if (!reset_n) begin
                    r_ch0 <= CTRL_00;
                    r_ch1 <= CTRL_00;
                    r_ch2 <= CTRL_00;
                end else begin
                    r_ch0 <= w_sym0;
                    r_ch1 <= w_sym1;
                    r_ch2 <= w_sym2;
                end
            end

            assign bus.tmds_ch0 = r_ch0;
            assign bus.tmds_ch1 = r_ch1;
            assign bus.tmds_ch2 = r_ch2;
        end else begin : g_no_out_reg
            assign bus.tmds_ch0 = w_sym0;
            assign bus.tmds_ch1 = w_sym1;
            assign bus.tmds_ch2 = w_sym2;
        end
    endgenerate

endmodule
`default_nettype wire
